// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with a valid/ready byte output.
//
// The serial line is synchronized, then a single FSM finds the start edge,
// confirms it at mid-bit, samples eight data bits LSB first at mid-bit and
// checks the stop bit. A good byte is presented one cycle after the stop
// sample and is held until the consumer takes it.
//
// Parameters
//   CLKS_PER_BIT : clk cycles per UART bit period (4..65535)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   rx        in   asynchronous serial line, idle high
//   rx_data   out  received byte, stable while rx_valid=1
//   rx_valid  out  rx_data holds an unconsumed byte
//   rx_ready  in   consumer accepts the byte when rx_valid=1
//   frame_err out  one-cycle pulse when a stop bit is sampled low
//   overrun   out  sticky, set when a completed byte had to be dropped
//   busy      out  FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [7:0]       r_shift;
    logic             r_dlv;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_rx_s;
    logic             w_xfer;

    assign w_rx_s = r_sync2;
    assign w_xfer = r_rx_valid & rx_ready;

    // Synchronizer flops reset to 1 so a reset never looks like a start edge
    // unless the line itself is actually low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a two-stage shift;
            // blocking ones would collapse it into a single flop.
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM. The counter restarts at every sample point, so each
    // sample is exactly CLKS_PER_BIT cycles after the previous one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= 3'd0;
            r_shift     <= 8'h00;
            r_dlv       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_dlv       <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= 3'd0;
                    if (!w_rx_s) begin
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt <= '0;
                        // A line back high at mid-bit was only a glitch.
                        r_state <= w_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        r_idx          <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_dlv   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    // A break or bad stop must end before a new start edge
                    // can be recognized.
                    if (w_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Output holding register with valid/ready handshake and overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end else if (r_dlv) begin
            if (!r_rx_valid || w_xfer) begin
                // Empty holder, or the old byte leaves this same cycle.
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else begin
                // Holder still occupied: the new byte is lost.
                r_overrun <= 1'b1;
            end
        end else if (w_xfer) begin
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- directed self-checking bench for uart_rx (CLKS_PER_BIT=16).
// Each task drives one scenario and compares DUT outputs against values
// worked out by hand for that scenario.
// ---------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Monitor totals, written only by the monitor process.
    int         valid_cycles = 0;
    int         xfer_cnt     = 0;
    int         fe_cycles    = 0;
    logic [7:0] last_xfer    = 8'h00;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observes pre-edge values at each rising edge, i.e. what the DUT sees.
    always @(posedge clk) begin
        if (rst) begin
            if (rx_valid) valid_cycles++;
            if (frame_err) fe_cycles++;
            if (rx_valid && rx_ready) begin
                xfer_cnt++;
                last_xfer = rx_data;
            end
        end
    end

    // Drives one 8N1 frame; called on a falling edge, returns on one.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
    endtask

    // Waits for busy to rise and then fall, bounded.
    task automatic wait_busy_fall(output bit ok);
        bit seen;
        seen = 1'b0;
        ok   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (busy) begin
                seen = 1'b1;
            end else if (seen) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst      = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        repeat (4) @(negedge clk);
        total_cnt++; if (rx_data !== 8'h00) $display("FAIL reset_data: got %h expected 00", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b expected 0", frame_err); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        int v0, x0, f0;
        v0 = valid_cycles; x0 = xfer_cnt; f0 = fe_cycles;
        rx_ready = 1'b1;
        send_frame(8'hA5, 1'b1);
        repeat (10) @(negedge clk);
        total_cnt++; if (valid_cycles - v0 !== 1) $display("FAIL basic_valid_cycles: got %0d expected 1", valid_cycles - v0); else pass_cnt++;
        total_cnt++; if (xfer_cnt - x0 !== 1) $display("FAIL basic_xfers: got %0d expected 1", xfer_cnt - x0); else pass_cnt++;
        total_cnt++; if (last_xfer !== 8'hA5) $display("FAIL basic_data: got %h expected a5", last_xfer); else pass_cnt++;
        total_cnt++; if (fe_cycles - f0 !== 0) $display("FAIL basic_frame_err: got %0d expected 0", fe_cycles - f0); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL basic_overrun: got %b expected 0", overrun); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL basic_valid_after: got %b expected 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_glitch;
        int v0, busy_cycles;
        v0 = valid_cycles;
        busy_cycles = 0;
        for (int i = 0; i < 60; i++) begin
            rx = (i < 8) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        total_cnt++; if (busy_cycles < 1 || busy_cycles > 10) $display("FAIL glitch_busy_cycles: got %0d expected 1..10", busy_cycles); else pass_cnt++;
        total_cnt++; if (valid_cycles - v0 !== 0) $display("FAIL glitch_valid: got %0d expected 0", valid_cycles - v0); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL glitch_busy_after: got %b expected 0", busy); else pass_cnt++;
    endtask

    task automatic test_frame_error;
        int v0, f0;
        v0 = valid_cycles; f0 = fe_cycles;
        rx_ready = 1'b1;
        send_frame(8'h3C, 1'b0);
        repeat (20) @(negedge clk);
        total_cnt++; if (busy !== 1'b1) $display("FAIL ferr_wait_high_busy: got %b expected 1", busy); else pass_cnt++;
        rx = 1'b1;
        repeat (6) @(negedge clk);
        total_cnt++; if (busy !== 1'b0) $display("FAIL ferr_idle_after_high: got %b expected 0", busy); else pass_cnt++;
        total_cnt++; if (fe_cycles - f0 !== 1) $display("FAIL ferr_pulse_cycles: got %0d expected 1", fe_cycles - f0); else pass_cnt++;
        total_cnt++; if (valid_cycles - v0 !== 0) $display("FAIL ferr_valid: got %0d expected 0", valid_cycles - v0); else pass_cnt++;
        send_frame(8'h81, 1'b1);
        repeat (10) @(negedge clk);
        total_cnt++; if (last_xfer !== 8'h81) $display("FAIL ferr_next_data: got %h expected 81", last_xfer); else pass_cnt++;
        total_cnt++; if (valid_cycles - v0 !== 1) $display("FAIL ferr_next_valid: got %0d expected 1", valid_cycles - v0); else pass_cnt++;
    endtask

    task automatic test_overrun;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        repeat (10) @(negedge clk);
        total_cnt++; if (rx_data !== 8'h11) $display("FAIL ovr_data_kept: got %h expected 11", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", rx_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b1) $display("FAIL ovr_flag_set: got %b expected 1", overrun); else pass_cnt++;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL ovr_valid_cleared: got %b expected 0", rx_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL ovr_flag_cleared: got %b expected 0", overrun); else pass_cnt++;
        total_cnt++; if (last_xfer !== 8'h11) $display("FAIL ovr_consumed_data: got %h expected 11", last_xfer); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        bit ok;
        rx_ready = 1'b0;
        send_frame(8'h11, 1'b1);
        repeat (4) @(negedge clk);
        total_cnt++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) $display("FAIL b2b_first_held: got valid=%b data=%h expected valid=1 data=11", rx_valid, rx_data); else pass_cnt++;
        // busy falls on the stop sample; the next cycle is the delivery cycle.
        fork
            send_frame(8'h22, 1'b1);
            begin
                wait_busy_fall(ok);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        total_cnt++; if (ok !== 1'b1) $display("FAIL b2b_busy_timeout: got %b expected 1", ok); else pass_cnt++;
        total_cnt++; if (last_xfer !== 8'h11) $display("FAIL b2b_consumed: got %h expected 11", last_xfer); else pass_cnt++;
        total_cnt++; if (rx_data !== 8'h22) $display("FAIL b2b_data: got %h expected 22", rx_data); else pass_cnt++;
        total_cnt++; if (rx_valid !== 1'b1) $display("FAIL b2b_valid: got %b expected 1", rx_valid); else pass_cnt++;
        total_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_overrun: got %b expected 0", overrun); else pass_cnt++;
        rx_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (rx_valid !== 1'b0) $display("FAIL b2b_drained: got %b expected 0", rx_valid); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame;
        int v0, f0;
        v0 = valid_cycles; f0 = fe_cycles;
        rx_ready = 1'b1;
        fork
            send_frame(8'hFF, 1'b1);
            begin
                // Half-way through data bit 4 (start + bits 0..3 + 8 cycles).
                repeat (CPB * 5 + 8) @(negedge clk);
                #2 rst = 1'b0;
                #1;
                total_cnt++; if (rx_data !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", rx_data); else pass_cnt++;
                total_cnt++; if (rx_valid !== 1'b0) $display("FAIL rstmid_valid: got %b expected 0", rx_valid); else pass_cnt++;
                total_cnt++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else pass_cnt++;
                total_cnt++; if (overrun !== 1'b0 || frame_err !== 1'b0) $display("FAIL rstmid_flags: got ovr=%b ferr=%b expected 0 0", overrun, frame_err); else pass_cnt++;
                @(negedge clk);
                rst = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        total_cnt++; if (valid_cycles - v0 !== 0) $display("FAIL rstmid_no_delivery: got %0d expected 0", valid_cycles - v0); else pass_cnt++;
        total_cnt++; if (fe_cycles - f0 !== 0) $display("FAIL rstmid_no_ferr: got %0d expected 0", fe_cycles - f0); else pass_cnt++;
        send_frame(8'h5A, 1'b1);
        repeat (10) @(negedge clk);
        total_cnt++; if (last_xfer !== 8'h5A) $display("FAIL rstmid_next_data: got %h expected 5a", last_xfer); else pass_cnt++;
        total_cnt++; if (valid_cycles - v0 !== 1) $display("FAIL rstmid_next_valid: got %0d expected 1", valid_cycles - v0); else pass_cnt++;
    endtask

    initial begin
        rst      = 1'b0;
        rx       = 1'b1;
        rx_ready = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_glitch;
        test_frame_error;
        test_overrun;
        test_back_to_back;
        test_reset_mid_frame;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
